// File: rtl/a2d_intf.sv
// a2d_intf: round-robin A2D sequencer in front of SPI_mnrch.
// Every 2^TMR_W clocks it runs one conversion on the next channel in the
// batt -> curr -> brake -> torque rotation. A conversion is two SPI
// transactions: the first selects the channel and the second reads the result.
// The latest 12-bit result of each channel is held for downstream logic.
module a2d_intf #(
  parameter int TMR_W = 14
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        done,
  input  logic [15:0] resp,
  output logic        snd,
  output logic [15:0] cmd,
  output logic [11:0] batt,
  output logic [11:0] curr,
  output logic [11:0] brake,
  output logic [11:0] torque,
  output logic        cnv_cmplt
);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    GAP,
    READ
  } state_t;

  state_t           state_reg, state_next;
  logic [TMR_W-1:0] timer_reg;
  logic [1:0]       rr_cnt_reg, rr_cnt_next;
  logic             snd_reg, snd_next;
  logic [15:0]      cmd_reg, cmd_next;
  logic             cnv_cmplt_reg;
  logic             wr_en;
  logic [2:0]       chnl;
  logic [11:0]      result_reg [4];

  // Map the rotation slot to the ADC128S channel (slots skip channel 2).
  always_comb begin
    chnl = 3'd0;
    case (rr_cnt_reg)
      2'd0:    chnl = 3'd0;
      2'd1:    chnl = 3'd1;
      2'd2:    chnl = 3'd3;
      default: chnl = 3'd4;
    endcase
  end

  // Free-running period timer; the FSM never restarts it, so the period stays fixed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timer_reg <= '0;
    else        timer_reg <= timer_reg + TMR_W'(1);
  end

  // Sequencer state and registered transaction outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      rr_cnt_reg    <= 2'd0;
      snd_reg       <= 1'b0;
      cmd_reg       <= 16'h0000;
      cnv_cmplt_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rr_cnt_reg    <= rr_cnt_next;
      snd_reg       <= snd_next;
      cmd_reg       <= cmd_next;
      cnv_cmplt_reg <= wr_en;
    end
  end

  // Next-state logic. A timer wrap seen outside IDLE is dropped rather than
  // queued, and done is only meaningful while a transaction is in flight.
  always_comb begin
    state_next  = state_reg;
    rr_cnt_next = rr_cnt_reg;
    snd_next    = 1'b0;
    cmd_next    = cmd_reg;
    wr_en       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (&timer_reg) begin
          snd_next   = 1'b1;
          cmd_next   = {2'b00, chnl, 11'h000};
          state_next = CMD;
        end
      end
      CMD: begin
        if (done) state_next = GAP;
      end
      GAP: begin
        snd_next   = 1'b1;
        state_next = READ;
      end
      READ: begin
        if (done) begin
          wr_en       = 1'b1;
          rr_cnt_next = rr_cnt_reg + 2'd1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // One result register per rotation slot; only the selected slot is written.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_result
      // Capture the low 12 bits of the read response for this slot.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              result_reg[gi] <= 12'h000;
        else if (wr_en && rr_cnt_reg == 2'(gi))  result_reg[gi] <= resp[11:0];
      end
    end
  endgenerate

  assign snd       = snd_reg;
  assign cmd       = cmd_reg;
  assign cnv_cmplt = cnv_cmplt_reg;
  assign batt      = result_reg[0];
  assign curr      = result_reg[1];
  assign brake     = result_reg[2];
  assign torque    = result_reg[3];

endmodule
